// File: rtl/tape_player.sv
// tape_player: cassette playback engine; fetches tape bytes and serialises them MSB-first as square-wave audio.
// Define TAPE_PLAYER_LOOP_EN to wrap to position 0 at end of tape instead of stopping.
module tape_player #(
    parameter int POS_W    = 24,
    parameter int BIT_CLKS = 6668
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             play,
    input  logic             stop,
    input  logic             rewind,
    input  logic [POS_W-1:0] tape_end,
    output logic [POS_W-1:0] ram_addr,
    input  logic [7:0]       ram_data,
    output logic [POS_W-1:0] pos,
    output logic             audio,
    output logic             motor,
    output logic             byte_strobe
);
    localparam int CW = $clog2(BIT_CLKS);
    localparam logic [CW-1:0] LAST = CW'(BIT_CLKS - 1);
    localparam logic [CW-1:0] Q1   = CW'(BIT_CLKS / 4);
    localparam logic [CW-1:0] Q2   = CW'(BIT_CLKS / 2);
    localparam logic [CW-1:0] Q3   = CW'(3 * (BIT_CLKS / 4));

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_SHIFT} state_t;

    state_t           r_state, w_state_n;
    logic [POS_W-1:0] r_pos, w_pos_n, w_pos_inc;
    logic [7:0]       r_shift, w_shift_n;
    logic [2:0]       r_bit, w_bit_n;
    logic [CW-1:0]    r_clk, w_clk_n;
    logic             r_audio, w_audio_n;
    logic             r_strobe, w_strobe_n;

    // A one bit is two short pulses, a zero bit is one long pulse.
    function automatic logic enc(input logic b, input logic [CW-1:0] c);
        return b ? (c < Q1 || (c >= Q2 && c < Q3)) : (c < Q2);
    endfunction

    assign w_pos_inc   = r_pos + POS_W'(1);
    assign ram_addr    = r_pos;
    assign pos         = r_pos;
    assign audio       = r_audio;
    assign motor       = r_state != S_IDLE;
    assign byte_strobe = r_strobe;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_pos    <= '0;
            r_shift  <= '0;
            r_bit    <= '0;
            r_clk    <= '0;
            r_audio  <= 1'b0;
            r_strobe <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_pos    <= w_pos_n;
            r_shift  <= w_shift_n;
            r_bit    <= w_bit_n;
            r_clk    <= w_clk_n;
            r_audio  <= w_audio_n;
            r_strobe <= w_strobe_n;
        end
    end

    always_comb begin
        w_state_n  = r_state;
        w_pos_n    = r_pos;
        w_shift_n  = r_shift;
        w_bit_n    = r_bit;
        w_clk_n    = r_clk;
        w_strobe_n = 1'b0;
        if (rewind) begin
            w_state_n = S_IDLE;
            w_pos_n   = '0;
        end else if (stop) begin
            w_state_n = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (play && tape_end != '0) begin
`ifdef TAPE_PLAYER_LOOP_EN
                        if (r_pos >= tape_end) w_pos_n = '0;
                        w_state_n = S_FETCH;
`else
                        if (r_pos < tape_end) w_state_n = S_FETCH;
`endif
                    end
                end
                S_FETCH: w_state_n = S_WAIT;
                S_WAIT: begin
                    w_shift_n  = ram_data;
                    w_bit_n    = 3'd7;
                    w_clk_n    = '0;
                    w_strobe_n = 1'b1;
                    w_state_n  = S_SHIFT;
                end
                S_SHIFT: begin
                    if (r_clk == LAST) begin
                        w_clk_n = '0;
                        if (r_bit != 3'd0) begin
                            w_bit_n   = r_bit - 3'd1;
                            w_shift_n = {r_shift[6:0], 1'b0};
                        end else begin
                            w_pos_n = w_pos_inc;
                            // >= also catches tape_end shrinking below pos mid-byte
`ifdef TAPE_PLAYER_LOOP_EN
                            if (w_pos_inc >= tape_end) w_pos_n = '0;
                            w_state_n = S_FETCH;
`else
                            w_state_n = (w_pos_inc >= tape_end) ? S_IDLE : S_FETCH;
`endif
                        end
                    end else begin
                        w_clk_n = r_clk + CW'(1);
                    end
                end
            endcase
        end
        w_audio_n = (w_state_n == S_SHIFT) && enc(w_shift_n[7], w_clk_n);
    end
endmodule
